// File: rtl/alu_word_seq_65ce02_pkg.sv
// Shared encodings for the 65CE02 word-op sequencer and its byte ALU.
package alu_word_seq_65ce02_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned OP_W   = 4;

    // Word command encodings (110/111 reserved)
    localparam logic [CMD_W-1:0] CMD_INW  = 3'b000;
    localparam logic [CMD_W-1:0] CMD_DEW  = 3'b001;
    localparam logic [CMD_W-1:0] CMD_ASW  = 3'b010;
    localparam logic [CMD_W-1:0] CMD_ROW  = 3'b011;
    localparam logic [CMD_W-1:0] CMD_ADDW = 3'b100;
    localparam logic [CMD_W-1:0] CMD_SUBW = 3'b101;

    // Byte ALU op selects; 11xx forces the ALU carry-in to 0
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_DBL  = 4'b1011;
    localparam logic [OP_W-1:0] ALU_PASS = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Decoded per-command ALU controls
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            use_b;
        logic            lo_ci;
    } dec_t;

    // Reserved commands occupy the 11x code space
    function automatic logic cmd_legal(input logic [CMD_W-1:0] c);
        return c[CMD_W-1:CMD_W-2] != 2'b11;
    endfunction

endpackage

// File: rtl/alu_word_seq_65ce02.sv
// Runs 16-bit word ops as two chained byte passes through the 8-bit ALU
// and collects the word result plus N/Z/C flags.
module alu_word_seq_65ce02
    import alu_word_seq_65ce02_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                RDY,
    input  logic                start,
    input  logic [CMD_W-1:0]    cmd,
    input  logic [WORD_W-1:0]   din_a,
    input  logic [WORD_W-1:0]   din_b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [WORD_W-1:0]   dout,
    output logic                c_out,
    output logic                n_out,
    output logic                z_out,
    output logic [OP_W-1:0]     alu_op,
    output logic                alu_right,
    output logic                alu_arith,
    output logic                alu_BCD,
    output logic [BYTE_W-1:0]   alu_AI,
    output logic [BYTE_W-1:0]   alu_BI,
    output logic                alu_CI,
    input  logic [BYTE_W-1:0]   alu_OUT,
    input  logic                alu_CO,
    input  logic                alu_N,
    input  logic                alu_Z
);

    // Command -> ALU op, B-operand source, and low-pass carry-in
    function automatic dec_t decode_cmd(input logic [CMD_W-1:0] c, input logic ci);
        dec_t d;
        d = '{op: ALU_PASS, use_b: 1'b0, lo_ci: 1'b0};
        case (c)
            CMD_INW:  d = '{op: ALU_ADD, use_b: 1'b0, lo_ci: 1'b1};
            CMD_DEW:  d = '{op: ALU_SUB, use_b: 1'b0, lo_ci: 1'b0};
            CMD_ASW:  d = '{op: ALU_DBL, use_b: 1'b0, lo_ci: 1'b0};
            CMD_ROW:  d = '{op: ALU_DBL, use_b: 1'b0, lo_ci: ci};
            CMD_ADDW: d = '{op: ALU_ADD, use_b: 1'b1, lo_ci: ci};
            CMD_SUBW: d = '{op: ALU_SUB, use_b: 1'b1, lo_ci: ci};
            default:  d = '{op: ALU_PASS, use_b: 1'b0, lo_ci: 1'b0};
        endcase
        return d;
    endfunction

    state_e              state_q, state_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic                cin_q, cin_d;
    logic [BYTE_W-1:0]   lo_res_q, lo_res_d;
    logic                lo_z_q, lo_z_d;
    logic [WORD_W-1:0]   dout_q, dout_d;
    logic                c_q, c_d;
    logic                n_q, n_d;
    logic                z_q, z_d;
    logic                done_q, done_d;
    dec_t                dec_c;

    // State and datapath registers; RDY=0 freezes everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            lo_res_q <= '0;
            lo_z_q   <= 1'b0;
            dout_q   <= '0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else if (RDY) begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            lo_res_q <= lo_res_d;
            lo_z_q   <= lo_z_d;
            dout_q   <= dout_d;
            c_q      <= c_d;
            n_q      <= n_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        lo_res_d = lo_res_q;
        lo_z_d   = lo_z_q;
        dout_d   = dout_q;
        c_d      = c_q;
        n_d      = n_q;
        z_d      = z_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && cmd_legal(cmd)) begin
                    cmd_d   = cmd;
                    a_d     = din_a;
                    b_d     = din_b;
                    cin_d   = cin;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                state_d = ST_HI;
            end
            ST_HI: begin
                // ALU now shows the registered low-byte result
                lo_res_d = alu_OUT;
                lo_z_d   = alu_Z;
                state_d  = ST_FIN;
            end
            ST_FIN: begin
                // ALU now shows the registered high-byte result
                dout_d  = {alu_OUT, lo_res_q};
                c_d     = alu_CO;
                n_d     = alu_N;
                z_d     = alu_Z & lo_z_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decode from latched command only, so start/din never reach the ALU drive
    always_comb begin
        dec_c = decode_cmd(cmd_q, cin_q);
    end

    // ALU drive: low bytes in LO, high bytes chained on the low carry in HI
    always_comb begin
        alu_op = ALU_PASS;
        alu_AI = '0;
        alu_BI = '0;
        alu_CI = 1'b0;
        case (state_q)
            ST_LO: begin
                alu_op = dec_c.op;
                alu_AI = a_q[BYTE_W-1:0];
                alu_BI = dec_c.use_b ? b_q[BYTE_W-1:0] : '0;
                alu_CI = dec_c.lo_ci;
            end
            ST_HI: begin
                alu_op = dec_c.op;
                alu_AI = a_q[WORD_W-1:BYTE_W];
                alu_BI = dec_c.use_b ? b_q[WORD_W-1:BYTE_W] : '0;
                alu_CI = alu_CO;
            end
            default: begin
                alu_op = ALU_PASS;
            end
        endcase
    end

    assign alu_right = 1'b0;
    assign alu_arith = 1'b0;
    assign alu_BCD   = 1'b0;

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign dout  = dout_q;
    assign c_out = c_q;
    assign n_out = n_q;
    assign z_out = z_q;

endmodule

// File: tb/tb_alu_word_seq_65ce02.sv
// Scoreboard bench for the word-op sequencer, with a byte ALU model attached.
module tb_alu_word_seq_65ce02;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RDY;
    logic        start;
    logic [2:0]  cmd;
    logic [15:0] din_a;
    logic [15:0] din_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic        c_out, n_out, z_out;
    logic [3:0]  alu_op;
    logic        alu_right, alu_arith, alu_BCD;
    logic [7:0]  alu_AI, alu_BI;
    logic        alu_CI;
    logic [7:0]  alu_OUT = 8'h00;
    logic        alu_CO = 1'b0;
    logic        alu_N = 1'b0;
    logic        alu_Z = 1'b0;
    logic [8:0]  alu_s;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic        n;
        logic        z;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    int unsigned rem      = 0;
    int unsigned rdy_cnt  = 0;
    bit          consumed = 1'b0;

    always #5 clk = ~clk;

    alu_word_seq_65ce02 dut (
        .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .cmd(cmd),
        .din_a(din_a), .din_b(din_b), .cin(cin), .busy(busy), .done(done),
        .dout(dout), .c_out(c_out), .n_out(n_out), .z_out(z_out),
        .alu_op(alu_op), .alu_right(alu_right), .alu_arith(alu_arith),
        .alu_BCD(alu_BCD), .alu_AI(alu_AI), .alu_BI(alu_BI), .alu_CI(alu_CI),
        .alu_OUT(alu_OUT), .alu_CO(alu_CO), .alu_N(alu_N), .alu_Z(alu_Z)
    );

    // Byte ALU model: add / subtract (B inverted) / double, registered, RDY-gated
    always_comb begin
        alu_s = {1'b0, alu_AI};
        case (alu_op)
            4'b0011: alu_s = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'h00, alu_CI};
            4'b0111: alu_s = {1'b0, alu_AI} + {1'b0, ~alu_BI} + {8'h00, alu_CI};
            4'b1011: alu_s = {1'b0, alu_AI} + {1'b0, alu_AI} + {8'h00, alu_CI};
            default: alu_s = {1'b0, alu_AI};
        endcase
    end

    always_ff @(posedge clk) begin
        if (RDY) begin
            alu_OUT <= alu_s[7:0];
            alu_CO  <= alu_s[8];
            alu_N   <= alu_s[7];
            alu_Z   <= (alu_s[7:0] == 8'h00);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Word-level reference: {z, n, c, result}
    function automatic logic [18:0] ref_word(input logic [2:0] c, input logic [15:0] a,
                                             input logic [15:0] b, input logic ci);
        logic [16:0] s;
        case (c)
            3'd0:    s = {1'b0, a} + 17'd1;
            3'd1:    s = {1'b0, a} + 17'h0FFFF;
            3'd2:    s = {a, 1'b0};
            3'd3:    s = {a, ci};
            3'd4:    s = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
            default: s = {1'b0, a} + {1'b0, ~b} + {16'h0000, ci};
        endcase
        return {(s[15:0] == 16'h0000), s[15], s[16], s[15:0]};
    endfunction

    // Acceptance model: push expectation when an idle, legal start meets a RDY edge
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem = 0;
            sb.delete();
        end else if (RDY) begin
            rdy_cnt++;
            if (rem == 0) begin
                if (start && cmd[2:1] != 2'b11) begin
                    logic [18:0] r;
                    exp_t e;
                    r    = ref_word(cmd, din_a, din_b, cin);
                    e.d  = r[15:0];
                    e.c  = r[16];
                    e.n  = r[17];
                    e.z  = r[18];
                    e.at = rdy_cnt;
                    sb.push_back(e);
                    rem = 3;
                end
            end else begin
                rem--;
            end
        end
    end

    // Monitor: busy every cycle, one scoreboard pop per done pulse
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(rem != 0));
        if (done && !consumed) begin
            chk("sb_nonempty_on_done", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", 32'(dout), 32'(e.d));
                chk("flags_czn", {29'd0, c_out, z_out, n_out}, {29'd0, e.c, e.z, e.n});
                chk("latency_rdy_edges", rdy_cnt - e.at, 32'd3);
            end
            consumed = 1'b1;
        end
        if (RDY) consumed = 1'b0;
    end

    task automatic issue(input logic [2:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic ci);
        start = 1'b1; cmd = c; din_a = a; din_b = b; cin = ci;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int unsigned edges);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_flags"}, {29'd0, c_out, n_out, z_out}, 32'd0);
        chk({tag, "_alu_drive"}, {alu_op, alu_AI, alu_BI, alu_CI, alu_right, alu_arith, alu_BCD},
            {4'hF, 8'h00, 8'h00, 4'h0});
    endtask

    logic [2:0]  v_cmd [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    logic [15:0] v_a   [9] = '{16'h00FF, 16'hFFFF, 16'h0000, 16'h0100, 16'h8001,
                               16'h4080, 16'h1234, 16'h1000, 16'h0000};
    logic [15:0] v_b   [9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0FCD, 16'h0001, 16'h0001};
    logic        v_ci  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int unsigned e;
        logic [18:0] r;
        reset_n = 1'b0; RDY = 1'b1; start = 1'b0; cmd = 3'd0;
        din_a = 16'h0000; din_b = 16'h0000; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, each issued in the previous done cycle
        for (int i = 0; i < 9; i++) begin
            issue(v_cmd[i], v_a[i], v_b[i], v_ci[i]);
            wait_done(e);
            chk("done_after_start", e, 32'd3);
        end

        // RDY stall for 3 cycles during HI, then hold done with RDY low
        issue(3'd4, 16'h1234, 16'h0FCD, 1'b0);
        @(posedge clk); #1;
        RDY = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        RDY = 1'b1;
        wait_done(e);
        chk("stall_done_delay", e + 32'd4, 32'd6);
        RDY = 1'b0;
        r = ref_word(3'd4, 16'h1234, 16'h0FCD, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("done_held", 32'(done), 32'd1);
            chk("dout_held", 32'(dout), 32'(r[15:0]));
        end
        RDY = 1'b1;
        @(posedge clk); #1;
        chk("done_cleared", 32'(done), 32'd0);

        // Reserved commands are ignored
        issue(3'b110, 16'h5555, 16'h1111, 1'b1);
        chk("reserved110_busy", 32'(busy), 32'd0);
        issue(3'b111, 16'h5555, 16'h1111, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("reserved_idle", 32'(busy), 32'd0);
        end

        // Reset pulsed during HI aborts with no done
        issue(3'd0, 16'h1234, 16'h0000, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("no_done_after_abort", 32'(done), 32'd0);
        end
        issue(3'd0, 16'h00FF, 16'h0000, 1'b0);
        wait_done(e);
        chk("post_reset_latency", e, 32'd3);
        @(posedge clk); #1;

        // Randomized traffic: starts while busy, reserved cmds, RDY gaps
        for (int i = 0; i < 600; i++) begin
            RDY   = (($urandom % 5) != 0);
            start = (($urandom % 3) == 0);
            cmd   = 3'($urandom);
            din_a = (($urandom % 4) == 0) ? 16'hFFFF : 16'($urandom);
            din_b = (($urandom % 4) == 0) ? 16'h0000 : 16'($urandom);
            cin   = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        RDY   = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
